// File: rtl/spi_master_seq_pkg.sv
// spi_seq_pkg: shared states, op/command encodings and frame word builder for spi_master_seq
package spi_seq_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_CMD, S_SHIFT, S_WAIT_RD, S_RECV, S_GAP, S_RESP
    } state_t;
    localparam logic OP_WR = 1'b0;
    localparam logic OP_RD = 1'b1;
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;
    localparam int FRAME_BITS = 10;
    localparam int RD_BITS = 8;

    function automatic logic [FRAME_BITS-1:0] frame_word(logic op, logic data, logic [7:0] addr, logic [7:0] wdata);
        logic [1:0] cmd;
        logic [7:0] payload;
        cmd = op == OP_RD ? (data ? CMD_RD_DATA : CMD_RD_ADDR) : (data ? CMD_WR_DATA : CMD_WR_ADDR);
        payload = !data ? addr : op == OP_WR ? wdata : 8'h00;
        return {cmd, payload};
    endfunction
endpackage

// File: rtl/spi_master_seq_if.sv
// spi_master_seq_if: request/response handshake plus SPI pins of the sequencer
interface spi_master_seq_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_op;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    modport master (
        input  req_valid, req_op, req_addr, req_wdata, MISO,
        output req_ready, rsp_valid, rsp_rdata, SS_n, MOSI
    );
    modport slave (
        output req_valid, req_op, req_addr, req_wdata, MISO,
        input  req_ready, rsp_valid, rsp_rdata, SS_n, MOSI
    );
endinterface

// File: rtl/spi_frame_shifter.sv
// spi_frame_shifter: 10-bit MSB-first MOSI shift register with bit counter
module spi_frame_shifter
    import spi_seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [FRAME_BITS-1:0] word,
    output logic                  msb,
    output logic [3:0]            bit_cnt,
    output logic                  done
);
    logic [FRAME_BITS-1:0] sr;

    // load clears the counter; each step emits the next bit and counts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            sr      <= word;
            bit_cnt <= '0;
        end else if (step) begin
            sr      <= {sr[FRAME_BITS-2:0], 1'b0};
            bit_cnt <= bit_cnt + 4'd1;
        end
    end

    assign msb  = sr[FRAME_BITS-1];
    assign done = bit_cnt == 4'(FRAME_BITS - 1);
endmodule

// File: rtl/spi_master_seq.sv
// spi_master_seq: turns one write/read request into framed SPI commands; SPI_SEQ_ADDR_SKIP_EN skips repeated address frames
module spi_master_seq
    import spi_seq_pkg::*;
#(
    parameter int RD_LAT  = 2,
    parameter int GAP_CYC = 1
) (
    input logic            clk,
    input logic            rst_n,
    spi_master_seq_if.master bus
);
    state_t     state, nxt;
    logic       op_q;
    logic [7:0] addr_q, wdata_q, rdata_q;
    logic [1:0] frame_idx;
    logic [3:0] wcnt, bit_cnt;
    logic       ss_q, rdy_q, accept, skip, load, step, sh_msb, sh_done;

    assign accept = state == S_IDLE && rdy_q && bus.req_valid;

`ifdef SPI_SEQ_ADDR_SKIP_EN
    logic       wr_v, rd_v;
    logic [7:0] wr_a, rd_a;
    assign skip = bus.req_op == OP_RD ? rd_v && bus.req_addr == rd_a : wr_v && bus.req_addr == wr_a;

    // remember the last address sent per op so a repeat can omit its address frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_v <= 1'b0;
            rd_v <= 1'b0;
            wr_a <= '0;
            rd_a <= '0;
        end else if (accept && bus.req_op == OP_RD) begin
            rd_v <= 1'b1;
            rd_a <= bus.req_addr;
        end else if (accept) begin
            wr_v <= 1'b1;
            wr_a <= bus.req_addr;
        end
    end
`else
    assign skip = 1'b0;
`endif

    spi_frame_shifter u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .step    (step),
        .word    (frame_word(op_q, frame_idx == 2'd1, addr_q, wdata_q)),
        .msb     (sh_msb),
        .bit_cnt (bit_cnt),
        .done    (sh_done)
    );

    // next-state decode and shifter control
    always_comb begin
        nxt  = state;
        load = 1'b0;
        step = 1'b0;
        case (state)
            S_IDLE:    nxt = accept ? S_START : S_IDLE;
            S_START:   nxt = S_CMD;
            S_CMD: begin
                nxt  = S_SHIFT;
                load = 1'b1;
            end
            S_SHIFT: begin
                step = 1'b1;
                if (sh_done) nxt = (op_q == OP_RD && frame_idx == 2'd1) ? S_WAIT_RD : S_GAP;
            end
            S_WAIT_RD: begin
                load = wcnt == 4'(RD_LAT - 1);
                nxt  = load ? S_RECV : S_WAIT_RD;
            end
            S_RECV: begin
                step = 1'b1;
                nxt  = bit_cnt == 4'(RD_BITS - 1) ? S_GAP : S_RECV;
            end
            S_GAP:     if (wcnt == 4'(GAP_CYC - 1)) nxt = frame_idx == 2'd0 ? S_START : S_RESP;
            S_RESP:    nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
    end

    // state, counters, registered SS_n/req_ready and request capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wcnt      <= '0;
            ss_q      <= 1'b1;
            rdy_q     <= 1'b0;
            op_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            frame_idx <= '0;
        end else begin
            state <= nxt;
            wcnt  <= nxt != state ? 4'd0 : wcnt + 4'd1;
            ss_q  <= !(nxt inside {S_START, S_CMD, S_SHIFT, S_WAIT_RD, S_RECV});
            rdy_q <= nxt == S_IDLE;
            if (accept) begin
                op_q      <= bus.req_op;
                addr_q    <= bus.req_addr;
                wdata_q   <= bus.req_wdata;
                rdata_q   <= '0;
                frame_idx <= skip ? 2'd1 : 2'd0;
            end else if (state == S_GAP && nxt == S_START) begin
                frame_idx <= 2'd1;
            end
            if (state == S_RECV) rdata_q <= {rdata_q[6:0], bus.MISO};
        end
    end

    assign bus.SS_n      = ss_q;
    assign bus.MOSI      = !ss_q && (state == S_CMD ? op_q : state == S_SHIFT && sh_msb);
    assign bus.req_ready = rdy_q;
    assign bus.rsp_valid = state == S_RESP;
    assign bus.rsp_rdata = rdata_q;
endmodule
